msg_feeder: RTL

- Stage directly upstream of the hash control/datapath.
- Accepts a message of known byte length from a host valid/ready stream and buffers it in a small FWFT FIFO.
- Presents bytes to the hash core with the F_dr/F_rtr handshake, then signals End_of_File.
- Issues the one-cycle start pulse that restarts the core, and holds End_of_File until the core reports H_ready.

---
 rtl/msg_feeder_pkg.sv | 15 +
 rtl/fifo_sync.sv | 65 ++++++
 rtl/msg_feeder.sv | 118 +++++++++++
 3 files changed

// File: rtl/msg_feeder_pkg.sv
// Shared types and default widths for the message feeder.
package msg_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_EOF   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

endpackage

// File: rtl/fifo_sync.sv
// First-word-fall-through FIFO with a registered head; dout reads 0 when empty.
// A word pushed at edge k is visible on dout after edge k.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_kept;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_kept = cnt_q - CW'(pop);
    cnt_d    = cnt_kept + CW'(push);
    // Next head: nothing left, the incoming word, or the next stored word.
    if (cnt_d == '0) begin
      dout_d = '0;
    end else if (cnt_kept == '0) begin
      dout_d = din;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/msg_feeder.sv
// Buffers a fixed-length host message and feeds it to the hash core over F_dr/F_rtr,
// then raises End_of_File until H_ready; pulses start once per message.
import msg_feeder_pkg::*;

module msg_feeder #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [DATA_W-1:0] M,
  output logic              F_dr,
  input  logic              F_rtr,
  output logic              End_of_File,
  output logic              start,
  input  logic              H_ready,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               start_q, start_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign host_ready = (state_q == S_LOAD) && !fifo_full && (rem_q != '0);
  assign push       = host_valid && host_ready;
  assign pop        = F_dr && F_rtr;
  assign F_dr       = !fifo_empty;

  fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (host_data),
    .dout  (M),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    start_d = 1'b0;
    eof_d   = 1'b0;
    if (push) begin
      rem_d = rem_q - LEN_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          state_d = S_LOAD;
          rem_d   = msg_len;
          start_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (rem_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No pushes happen here, so an empty FIFO stays empty.
        if (fifo_empty) begin
          state_d = S_EOF;
          eof_d   = 1'b1;
        end
      end
      S_EOF: begin
        if (H_ready) begin
          state_d = S_DONE;
        end else begin
          eof_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      start_q <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      start_q <= start_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  assign start       = start_q;
  assign End_of_File = eof_q;
  assign busy        = busy_q;

endmodule
